// File: rtl/button_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// button_pkg : state encoding and 100 MHz timing defaults for button stepping
// Revision   : 1.0
// ----------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [1:0] {
    LOCKOUT = 2'd0,
    IDLE    = 2'd1,
    HELD    = 2'd2,
    REPEAT  = 2'd3
  } btn_state_e;

  localparam int HOLD_CYCLES_DEF   = 50_000_000;
  localparam int REPEAT_CYCLES_DEF = 10_000_000;
  localparam int PENDING_W_DEF     = 3;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_step_controller_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// button_step_controller_if : step request valid/ready handshake with count
// Revision                  : 1.0
// ----------------------------------------------------------------------------
interface button_step_controller_if #(
  parameter int PENDING_W = 3
);
  logic                 step_valid;
  logic                 step_ready;
  logic [PENDING_W-1:0] pending;

  modport master (output step_valid, output pending, input step_ready);
  modport slave  (input step_valid, input pending, output step_ready);
endinterface
`default_nettype wire

// File: rtl/step_pending_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// step_pending_counter : saturating queued-step counter with sticky overflow
// Revision             : 1.0
// ----------------------------------------------------------------------------
module step_pending_counter #(
  parameter int PENDING_W = 3
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  i_event,
  input  wire                  i_step_ready,
  input  wire                  i_clr_overflow,
  output logic                 o_step_valid,
  output logic [PENDING_W-1:0] o_pending,
  output logic                 o_overflow
);

  logic [PENDING_W-1:0] r_pending;
  logic                 r_overflow;
  logic                 w_valid;
  logic                 w_xfer;
  logic                 w_full;
  logic                 w_drop;

  assign w_valid = (r_pending != '0);
  assign w_xfer  = w_valid & i_step_ready;
  assign w_full  = &r_pending;
  // A simultaneous event and transfer nets to zero, so saturation never drops it.
  assign w_drop  = i_event & ~w_xfer & w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_event && !w_xfer && !w_full) begin
        r_pending <= r_pending + PENDING_W'(1);
      end else if (w_xfer && !i_event) begin
        r_pending <= r_pending - PENDING_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_step_valid = w_valid;
  assign o_pending    = r_pending;
  assign o_overflow   = r_overflow;

endmodule
`default_nettype wire

// File: rtl/button_step_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// button_step_controller : button level to single-step requests with repeat
// Revision               : 1.0
// ----------------------------------------------------------------------------
module button_step_controller
  import button_pkg::*;
#(
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int PENDING_W     = PENDING_W_DEF
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  i_btn_level,
  input  wire  i_enable,
  input  wire  i_clr_overflow,
  output logic o_long_press,
  output logic o_overflow,
  button_step_controller_if.master bus
);

  localparam int TW = $clog2(max_i(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [TW-1:0] C_HOLD_LAST   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] C_REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

  localparam logic [1:0] S_LOCKOUT = LOCKOUT;
  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_HELD    = HELD;
  localparam logic [1:0] S_REPEAT  = REPEAT;

  logic [1:0]    r_state;
  logic [TW-1:0] r_timer;
  logic          w_event;
  logic          w_hold_done;
  logic          w_rep_done;

  assign w_hold_done = (r_timer == C_HOLD_LAST);
  assign w_rep_done  = (r_timer == C_REPEAT_LAST);

  always_comb begin
    w_event = 1'b0;
    if (i_enable && i_btn_level) begin
      case (r_state)
        S_IDLE:   w_event = 1'b1;
        S_HELD:   w_event = w_hold_done;
        S_REPEAT: w_event = w_rep_done;
        default:  w_event = 1'b0;
      endcase
    end
  end

  // Disable wins over every transition and forces a fresh release before the next press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOCKOUT;
      r_timer <= '0;
    end else if (!i_enable) begin
      r_state <= S_LOCKOUT;
      r_timer <= '0;
    end else begin
      case (r_state)
        S_LOCKOUT: begin
          if (!i_btn_level) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (i_btn_level) begin
            r_state <= S_HELD;
            r_timer <= '0;
          end
        end
        S_HELD: begin
          if (!i_btn_level) begin
            r_state <= S_IDLE;
          end else if (w_hold_done) begin
            r_state <= S_REPEAT;
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_REPEAT: begin
          if (!i_btn_level) begin
            r_state <= S_IDLE;
          end else if (w_rep_done) begin
            r_timer <= '0;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        default: begin
          r_state <= S_LOCKOUT;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign o_long_press = (r_state == S_REPEAT);

  step_pending_counter #(
    .PENDING_W (PENDING_W)
  ) u_pending (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_event        (w_event),
    .i_step_ready   (bus.step_ready),
    .i_clr_overflow (i_clr_overflow),
    .o_step_valid   (bus.step_valid),
    .o_pending      (bus.pending),
    .o_overflow     (o_overflow)
  );

endmodule
`default_nettype wire

// File: tb/tb_button_step_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_button_step_controller : directed stimulus, transfer-edge scoreboard
// Revision                  : 1.0
// ----------------------------------------------------------------------------
module tb_button_step_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic en;
  logic clr;
  logic long_press;
  logic overflow;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int k;
  int e;
  int mon_e;
  int exp_q[$];

  button_step_controller_if #(.PENDING_W(2)) u_if ();

  button_step_controller #(
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .PENDING_W     (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_btn_level    (btn),
    .i_enable       (en),
    .i_clr_overflow (clr),
    .o_long_press   (long_press),
    .o_overflow     (overflow),
    .bus            (u_if.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press();
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard: each queued entry is the clock edge at which a transfer must occur.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && u_if.step_valid && u_if.step_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL xfer_unexpected: got edge %0d expected none", cyc + 1);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e != cyc + 1) begin
            bad++;
            $display("FAIL xfer_edge: got edge %0d expected edge %0d", cyc + 1, mon_e);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; btn = 1'b0; en = 1'b0; clr = 1'b0;
    u_if.step_ready = 1'b0;
    #1;
    check("rst_valid", int'(u_if.step_valid), 0);
    check("rst_pending", int'(u_if.pending), 0);
    check("rst_long", int'(long_press), 0);
    check("rst_ovf", int'(overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    repeat (2) @(negedge clk);

    // short press
    u_if.step_ready = 1'b1; btn = 1'b1; k = cyc + 1;
    exp_q.push_back(k + 1);
    @(negedge clk);
    check("short_valid_rise", int'(u_if.step_valid), 1);
    check("short_pending", int'(u_if.pending), 1);
    @(negedge clk);
    check("short_valid_fall", int'(u_if.step_valid), 0);
    @(negedge clk);
    btn = 1'b0;
    check("short_long", int'(long_press), 0);
    repeat (2) @(negedge clk);

    // hold with auto-repeat
    btn = 1'b1; k = cyc + 1;
    exp_q.push_back(k + 1); exp_q.push_back(k + 9);
    exp_q.push_back(k + 13); exp_q.push_back(k + 17);
    repeat (8) @(negedge clk);
    check("hold_long_before", int'(long_press), 0);
    @(negedge clk);
    check("hold_long_rise", int'(long_press), 1);
    repeat (11) @(negedge clk);
    btn = 1'b0;
    check("hold_long_held", int'(long_press), 1);
    @(negedge clk);
    check("hold_long_fall", int'(long_press), 0);
    repeat (2) @(negedge clk);

    // saturation and overflow
    u_if.step_ready = 1'b0;
    repeat (3) press();
    check("sat_pending3", int'(u_if.pending), 3);
    check("sat_ovf_before", int'(overflow), 0);
    press();
    check("sat_ovf_set", int'(overflow), 1);
    check("sat_pending_hold", int'(u_if.pending), 3);
    press();
    check("sat_pending_5th", int'(u_if.pending), 3);
    u_if.step_ready = 1'b1; e = cyc + 1;
    exp_q.push_back(e); exp_q.push_back(e + 1); exp_q.push_back(e + 2);
    repeat (4) @(negedge clk);
    check("sat_drained", int'(u_if.pending), 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovf_cleared", int'(overflow), 0);
    u_if.step_ready = 1'b0;
    repeat (3) press();
    check("sat2_ovf", int'(overflow), 0);
    clr = 1'b1; btn = 1'b1;
    @(negedge clk);
    clr = 1'b0; btn = 1'b0;
    check("ovf_set_beats_clr", int'(overflow), 1);
    @(negedge clk);
    u_if.step_ready = 1'b1; e = cyc + 1;
    exp_q.push_back(e); exp_q.push_back(e + 1); exp_q.push_back(e + 2);
    repeat (4) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // simultaneous event and transfer
    u_if.step_ready = 1'b0;
    press();
    check("sim_pre_pending", int'(u_if.pending), 1);
    btn = 1'b1; u_if.step_ready = 1'b1; e = cyc + 1;
    exp_q.push_back(e); exp_q.push_back(e + 1);
    @(negedge clk);
    btn = 1'b0;
    check("sim_pending", int'(u_if.pending), 1);
    check("sim_valid", int'(u_if.step_valid), 1);
    repeat (3) @(negedge clk);
    check("sim_drained", int'(u_if.pending), 0);

    // enable drop mid-repeat, re-enable while held
    btn = 1'b1; k = cyc + 1;
    exp_q.push_back(k + 1); exp_q.push_back(k + 9);
    repeat (10) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    check("dis_long", int'(long_press), 0);
    check("dis_pending", int'(u_if.pending), 0);
    en = 1'b1;
    repeat (6) @(negedge clk);
    check("reen_held_pending", int'(u_if.pending), 0);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    btn = 1'b1; k = cyc + 1;
    exp_q.push_back(k + 1);
    @(negedge clk);
    btn = 1'b0;
    check("reen_repress_valid", int'(u_if.step_valid), 1);
    repeat (3) @(negedge clk);

    // asynchronous reset mid-repeat
    u_if.step_ready = 1'b0; btn = 1'b1;
    repeat (9) @(negedge clk);
    check("mid_long", int'(long_press), 1);
    check("mid_pending", int'(u_if.pending), 2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(u_if.step_valid), 0);
    check("arst_pending", int'(u_if.pending), 0);
    check("arst_long", int'(long_press), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_held", int'(u_if.pending), 0);
    btn = 1'b0;
    repeat (2) @(negedge clk);
    u_if.step_ready = 1'b1; btn = 1'b1; k = cyc + 1;
    exp_q.push_back(k + 1);
    @(negedge clk);
    btn = 1'b0;
    repeat (5) @(negedge clk);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
